vram_rect_fill: RTL and testbench

//  Command-driven rectangle fill engine feeding the write port of the 640x360 VRAM
//  (6-bit palette-index framebuffer). It accepts one rectangle command at a time,

---
 rtl/vram_rect_fill.sv | 213 +++++++++++++++++++++
 tb/tb_vram_rect_fill.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_rect_fill.sv
// Rectangle fill engine: accepts one clipped rectangle command at a time and
// streams raster-ordered palette-index writes into the 640x360 VRAM write port.
module vram_rect_fill #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 360,
    parameter int ADDR_WIDTH    = 18,
    parameter int DATA_WIDTH    = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [9:0]            i_cmd_x,
    input  logic [8:0]            i_cmd_y,
    input  logic [9:0]            i_cmd_w,
    input  logic [8:0]            i_cmd_h,
    input  logic [DATA_WIDTH-1:0] i_cmd_colour,
    input  logic                  i_stall,
    output logic                  o_write,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [10:0]           X_LIMIT    = 11'(SCREEN_WIDTH);
    localparam logic [9:0]            Y_LIMIT    = 10'(SCREEN_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(SCREEN_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_FILL,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [9:0]              x0_q, x0_d;
    logic [8:0]              y0_q, y0_d;
    logic [9:0]              w_q, w_d;
    logic [8:0]              h_q, h_d;
    logic [DATA_WIDTH-1:0]   colour_q, colour_d;
    logic [9:0]              x_q, x_d;
    logic [8:0]              y_q, y_d;
    logic [10:0]             x_end_q, x_end_d;
    logic [9:0]              y_end_q, y_end_d;
    logic [ADDR_WIDTH-1:0]   row_base_q, row_base_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    write_en_q, write_en_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    ready_q, ready_d;

    logic [10:0]             x_sum;
    logic [9:0]              y_sum;
    logic [10:0]             x_end_clip;
    logic [9:0]              y_end_clip;
    logic                    is_empty;
    logic [ADDR_WIDTH-1:0]   setup_row_base;
    logic [10:0]             x_next;
    logic [9:0]              y_next;
    logic                    row_last;
    logic                    rect_last;
    logic                    advance;

    // Clip arithmetic is one bit wider than the coordinates so x0+w never wraps.
    always_comb begin
        x_sum          = {1'b0, x0_q} + {1'b0, w_q};
        y_sum          = {1'b0, y0_q} + {1'b0, h_q};
        x_end_clip     = (x_sum > X_LIMIT) ? X_LIMIT : x_sum;
        y_end_clip     = (y_sum > Y_LIMIT) ? Y_LIMIT : y_sum;
        is_empty       = (w_q == 10'd0) || (h_q == 9'd0) ||
                         ({1'b0, x0_q} >= X_LIMIT) || ({1'b0, y0_q} >= Y_LIMIT);
        setup_row_base = ADDR_WIDTH'(y0_q) * ROW_STRIDE;
        x_next         = {1'b0, x_q} + 11'd1;
        y_next         = {1'b0, y_q} + 10'd1;
        row_last       = (x_next == x_end_q);
        rect_last      = (y_next == y_end_q);
        advance        = (state_q == S_FILL) && write_en_q && !i_stall;
    end

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        colour_d   = colour_q;
        x_d        = x_q;
        y_d        = y_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        data_d     = data_q;
        write_en_d = write_en_q;
        done_d     = done_q;
        busy_d     = busy_q;
        ready_d    = ready_q;

        case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    x0_d     = i_cmd_x;
                    y0_d     = i_cmd_y;
                    w_d      = i_cmd_w;
                    h_d      = i_cmd_h;
                    colour_d = i_cmd_colour;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (is_empty) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    x_d        = x0_q;
                    y_d        = y0_q;
                    x_end_d    = x_end_clip;
                    y_end_d    = y_end_clip;
                    row_base_d = setup_row_base;
                    addr_d     = setup_row_base + ADDR_WIDTH'(x0_q);
                    data_d     = colour_q;
                    write_en_d = 1'b1;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                // Position only moves on cycles where the write actually went out.
                if (advance) begin
                    if (!row_last) begin
                        x_d    = x_next[9:0];
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end else if (!rect_last) begin
                        x_d        = x0_q;
                        y_d        = y_next[8:0];
                        row_base_d = row_base_q + ROW_STRIDE;
                        addr_d     = row_base_q + ROW_STRIDE + ADDR_WIDTH'(x0_q);
                    end else begin
                        write_en_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                write_en_d = 1'b0;
                done_d     = 1'b0;
                busy_d     = 1'b0;
                ready_d    = 1'b1;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            colour_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            write_en_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            colour_q   <= colour_d;
            x_q        <= x_d;
            y_q        <= y_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            write_en_q <= write_en_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    // A stall must suppress the write in the same cycle the port reports busy.
    assign o_write     = write_en_q & ~i_stall;
    assign o_addr      = addr_q;
    assign o_data      = data_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_cmd_ready = ready_q;

endmodule

// File: tb/tb_vram_rect_fill.sv
// Directed self-checking bench for vram_rect_fill: a reference model pushes the
// expected write stream into a scoreboard queue that a negedge monitor drains.
module tb_vram_rect_fill;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_x;
   logic [8:0]  cmd_y;
   logic [9:0]  cmd_w;
   logic [8:0]  cmd_h;
   logic [5:0]  cmd_colour;
   logic        stall;
   logic        wr;
   logic [17:0] addr;
   logic [5:0]  data;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int nwrites = 0;
   int first_wr = -1;
   int last_wr = -1;
   int acc_cyc = 0;
   int done_cyc = 0;
   logic [23:0] exp_q[$];
   logic [23:0] mon_exp;

   vram_rect_fill dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_cmd_valid  (cmd_valid),
      .o_cmd_ready  (cmd_ready),
      .i_cmd_x      (cmd_x),
      .i_cmd_y      (cmd_y),
      .i_cmd_w      (cmd_w),
      .i_cmd_h      (cmd_h),
      .i_cmd_colour (cmd_colour),
      .i_stall      (stall),
      .o_write      (wr),
      .o_addr       (addr),
      .o_data       (data),
      .o_busy       (busy),
      .o_done       (done)
   );

   // 100 MHz clock and a free-running cycle counter used for latency checks
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Every observed write is matched against the head of the scoreboard queue
   always @(negedge clk) begin
      if (rst_n && wr) begin
         mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hFFFFFF;
         checks++;
         assert ({addr, data} === mon_exp) else begin
            errors++;
            $error("[TB] FAIL write observed addr=%0d data=%0h expected addr=%0d data=%0h",
                   addr, data, mon_exp[23:6], mon_exp[5:0]);
         end
         if (first_wr < 0) first_wr = cyc;
         last_wr = cyc;
         nwrites++;
      end
   end

   // Safety net so the run always ends even if the DUT wedges
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point: counts the check and reports tag/observed/expected
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Drives one command and pushes the clipped raster stream the model predicts
   task automatic applyStimulus(input int x, input int y, input int w, input int h, input int col);
      int xe;
      int ye;
      int k;
      xe = (x + w > 640) ? 640 : x + w;
      ye = (y + h > 360) ? 360 : y + h;
      for (int yy = y; yy < ye; yy++)
         for (int xx = x; xx < xe; xx++)
            exp_q.push_back({18'(yy * 640 + xx), 6'(col)});
      nwrites  = 0;
      first_wr = -1;
      last_wr  = -1;
      @(negedge clk);
      for (k = 0; k < 50 && !cmd_ready; k++) @(negedge clk);
      checkOutput("ready_before_cmd", 32'(cmd_ready), 32'd1);
      cmd_valid  = 1'b1;
      cmd_x      = 10'(x);
      cmd_y      = 9'(y);
      cmd_w      = 10'(w);
      cmd_h      = 9'(h);
      cmd_colour = 6'(col);
      acc_cyc    = cyc;
      @(negedge clk);
      cmd_valid  = 1'b0;
      cmd_x      = '1;
      cmd_y      = '1;
      cmd_w      = '1;
      cmd_h      = '1;
      cmd_colour = '1;
   endtask

   // Waits (bounded) for the done pulse and checks the DONE/IDLE handover
   task automatic waitDone(input int limit);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < limit; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            done_cyc = cyc;
            break;
         end
      end
      checkOutput("done_seen", 32'(seen), 32'd1);
      checkOutput("busy_in_done", 32'(busy), 32'd1);
      checkOutput("write_in_done", 32'(wr), 32'd0);
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      checkOutput("ready_after_done", 32'(cmd_ready), 32'd1);
      checkOutput("busy_after_done", 32'(busy), 32'd0);
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      int k;
      rst_n      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_x      = '0;
      cmd_y      = '0;
      cmd_w      = '0;
      cmd_h      = '0;
      cmd_colour = '0;
      stall      = 1'b0;
      #1;
      checkOutput("rst_write", 32'(wr), 32'd0);
      checkOutput("rst_addr", 32'(addr), 32'd0);
      checkOutput("rst_data", 32'(data), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_ready", 32'(cmd_ready), 32'd1);

      $display("[TB] basic 3x2 rectangle");
      applyStimulus(10, 20, 3, 2, 'h2A);
      waitDone(50);
      checkOutput("t1_nwrites", 32'(nwrites), 32'd6);
      checkOutput("t1_first_latency", 32'(first_wr - acc_cyc), 32'd2);
      checkOutput("t1_done_after_last", 32'(done_cyc - last_wr), 32'd1);

      $display("[TB] clipped corner rectangle");
      applyStimulus(638, 358, 5, 5, 'h3F);
      waitDone(50);
      checkOutput("t3_nwrites", 32'(nwrites), 32'd4);

      $display("[TB] empty commands");
      applyStimulus(100, 100, 0, 4, 'h11);
      waitDone(20);
      checkOutput("t4_w0_nwrites", 32'(nwrites), 32'd0);
      checkOutput("t4_w0_done_lat", 32'(done_cyc - acc_cyc), 32'd2);
      applyStimulus(700, 10, 5, 5, 'h12);
      waitDone(20);
      checkOutput("t4_x700_nwrites", 32'(nwrites), 32'd0);
      checkOutput("t4_x700_done_lat", 32'(done_cyc - acc_cyc), 32'd2);
      applyStimulus(10, 400, 5, 5, 'h13);
      waitDone(20);
      checkOutput("t4_y400_nwrites", 32'(nwrites), 32'd0);
      checkOutput("t4_y400_done_lat", 32'(done_cyc - acc_cyc), 32'd2);

      $display("[TB] stall after second write");
      applyStimulus(10, 20, 3, 2, 'h15);
      for (k = 0; k < 20; k++) begin
         @(posedge clk);
         if (nwrites >= 2) break;
      end
      checkOutput("t5_reached_two", 32'(nwrites), 32'd2);
      #1 stall = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("t5_stall_write", 32'(wr), 32'd0);
         checkOutput("t5_stall_addr", 32'(addr), 32'd12812);
      end
      @(posedge clk);
      #1 stall = 1'b0;
      waitDone(50);
      checkOutput("t5_nwrites", 32'(nwrites), 32'd6);
      checkOutput("t5_done_lat", 32'(done_cyc - acc_cyc), 32'd11);

      $display("[TB] full screen fill interrupted by reset");
      applyStimulus(0, 0, 640, 360, 0);
      for (k = 0; k < 6000; k++) begin
         @(posedge clk);
         if (nwrites >= 5000) break;
      end
      checkOutput("t6_progress", 32'(nwrites), 32'd5000);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_write", 32'(wr), 32'd0);
      checkOutput("t6_rst_busy", 32'(busy), 32'd0);
      checkOutput("t6_rst_addr", 32'(addr), 32'd0);
      exp_q.delete();
      repeat (3) begin
         @(negedge clk);
         checkOutput("t6_no_done_in_rst", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checkOutput("t6_no_done_after", 32'(done), 32'd0);
         checkOutput("t6_no_write_after", 32'(wr), 32'd0);
      end
      checkOutput("t6_ready_after", 32'(cmd_ready), 32'd1);

      applyStimulus(5, 3, 4, 1, 'h07);
      waitDone(50);
      checkOutput("t6_new_nwrites", 32'(nwrites), 32'd4);
      checkOutput("t6_new_latency", 32'(first_wr - acc_cyc), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
